// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one fixed-latency memory port between IF and MEM stages.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed MEM-over-IF priority.
module fetch_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_req,
    input  logic              mem_wr_req,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze_if,
    output logic              freeze_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic          owner_mem, wr, mem_req, grant, pick_mem, last;

    assign mem_req = mem_rd_req | mem_wr_req;
    assign last    = cnt == CW'(WAIT_STATES - 1);

`ifdef ARB_RR_EN
    logic rr_mem;
    assign pick_mem = mem_req & (~if_req | rr_mem);
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_mem <= 1'b1;
        else if (grant) rr_mem <= ~pick_mem;
`else
    assign pick_mem = mem_req;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;

    always_comb begin
        grant   = (state == IDLE) & (mem_req | if_req);
        state_n = grant ? ACCESS : (state == ACCESS) ? (last ? DONE : ACCESS) : IDLE;
    end

    assign ram_en     = state == ACCESS;
    assign ram_we     = ram_en & wr;
    assign if_ready   = (state == DONE) & ~owner_mem;
    assign mem_ready  = (state == DONE) & owner_mem;
    assign freeze_if  = if_req & ~if_ready;
    assign freeze_mem = mem_req & ~mem_ready;

    // Request, address and data are only sampled at grant; ACCESS runs on the latched copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            owner_mem <= 1'b0;
            wr        <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            if (grant) begin
                cnt       <= '0;
                owner_mem <= pick_mem;
                wr        <= pick_mem & mem_wr_req;
                ram_addr  <= pick_mem ? mem_addr : if_addr;
                ram_wdata <= mem_wdata;
            end
            if (state == ACCESS) cnt <= cnt + 1'b1;
            if (state == ACCESS && last && !wr && owner_mem) mem_rdata <= ram_rdata;
            if (state == ACCESS && last && !wr && !owner_mem) if_rdata <= ram_rdata;
        end
    end
endmodule

// File: doc/fetch_mem_arbiter.md
# fetch_mem_arbiter

Arbiter and sequencer for a single-port, fixed-latency unified memory shared by the IF stage (instruction fetch) and the MEM stage (load/store). It grants one requester at a time and drives the memory port for exactly `WAIT_STATES` cycles. It returns registered data with a one-cycle ready pulse and produces per-stage freeze signals for the pipeline. It sits between the IF/MEM stages and the external memory model.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `WAIT_STATES`, 4, memory access cycles per transaction; legal values ≥1
- Reset `rst` is asynchronous and active-high; the clock is `clk`.
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous active-high reset
- `if_req`  in  1  fetch read request, level, held until `if_ready`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetched instruction, registered
- `if_ready`  out  1  one-cycle completion pulse for fetch
- `mem_rd_req`  in  1  data read request, level
- `mem_wr_req`  in  1  data write request, level
- `mem_addr`  in  ADDR_W  data address
- `mem_wdata`  in  DATA_W  store data
- `mem_rdata`  out  DATA_W  load data, registered
- `mem_ready`  out  1  one-cycle completion pulse for data access
- `freeze_if`  out  1  `if_req & ~if_ready`
- `freeze_mem`  out  1  `(mem_rd_req|mem_wr_req) & ~mem_ready`
- `ram_en`  out  1  memory access active
- `ram_we`  out  1  memory write
- `ram_addr`  out  ADDR_W  memory address, registered
- `ram_wdata`  out  DATA_W  memory write data, registered
- `ram_rdata`  in  DATA_W  memory read data, valid on the last ACCESS cycle

## Operation
- FSM states:
  - IDLE: arbitrate on pending requests.
    - MEM request present → grant MEM.
    - Otherwise, `if_req` present → grant IF.
    - On grant: latch `ram_addr`, `ram_wdata`, write flag, and owner; clear the counter; go to ACCESS.
    - No request → stay in IDLE.
  - ACCESS: `ram_en`=1; `ram_we`=1 for the whole state if the access is a write. The counter increments each cycle. On the cycle where the count equals `WAIT_STATES-1`, `ram_rdata` is captured into the owner's rdata register (reads only), then go to DONE.
  - DONE: assert the owner's ready for one cycle, then return to IDLE unconditionally.
- Default priority: fixed, MEM over IF (the older instruction wins).
- When `mem_rd_req` and `mem_wr_req` are both set, the access is a write. `mem_rdata` keeps its previous value.
- Writes never update either rdata register.
- Request inputs are sampled only in IDLE. Changes to address or data during ACCESS are ignored.
- A request deasserted mid-access does not abort the transaction: it completes and the ready pulse is still issued.
- A request still high in the cycle after DONE is treated as a new transaction.
- Reset values:
  - State IDLE, counter 0.
  - `if_rdata` = `mem_rdata` = 0.
  - `if_ready` = `mem_ready` = 0.
  - `ram_en` = `ram_we` = 0; `ram_addr` = `ram_wdata` = 0.
  - Round-robin pointer set to "MEM next".
  - Freeze outputs follow their combinational definitions.

## Timing
- Request seen in IDLE at cycle 0 → ACCESS in cycles 1..`WAIT_STATES` → ready pulse at cycle `WAIT_STATES+1`.
- Back-to-back transactions therefore cost `WAIT_STATES+2` cycles each, because IDLE re-arbitrates after DONE.
- `rdata` updates on the clock edge entering DONE and is stable during the ready pulse and afterwards, until the next read by the same owner.
- Freeze outputs are combinational from the inputs and the registered ready, with no added latency.
- `rst` asserted in any state forces reset values immediately, without waiting for `clk`. An in-flight transaction is dropped and no ready pulse is issued.

## Configuration
- `ARB_RR_EN` defined: round-robin arbitration.
  - When both requesters are pending in IDLE, the grant goes to the one not granted last.
  - The pointer updates on every grant.
  - A lone requester is always granted.
- `ARB_RR_EN` undefined: fixed MEM-over-IF priority; IF can starve under continuous MEM traffic.

## Test plan
- Reset: assert `rst` with random inputs → all registered outputs 0, `ram_en`=0, state IDLE.
- Lone fetch, `WAIT_STATES`=4: `if_req`=1, `if_addr`=0x10, `ram_rdata`=0xE3A00001 → `ram_en`=1 in cycles 1-4 with `ram_addr`=0x10; `if_ready`=1 in cycle 5 only; `if_rdata`=0xE3A00001; `freeze_if`=1 in cycles 0-4.
- Contention: `if_req` and `mem_rd_req` both set at cycle 0, fixed priority → `mem_ready` at cycle 5, IF granted at cycle 6, `if_ready` at cycle 11, `freeze_if` high in cycles 0-10.
- Store: `mem_wr_req`=1, `mem_addr`=0x100, `mem_wdata`=0xDEADBEEF → `ram_we`=`ram_en`=1 in cycles 1-4 with `ram_wdata`=0xDEADBEEF; `mem_ready` at cycle 5; `mem_rdata` unchanged.
- Reset mid-op: assert `rst` in ACCESS cycle 2 → `ram_en` drops asynchronously; no ready pulse; after release, a new request restarts at IDLE timing.
- Fairness: both requesters held high for 30 cycles.
  - With `ARB_RR_EN`: grants alternate MEM, IF, MEM…
  - Without `ARB_RR_EN`: all grants go to MEM and `if_ready` never asserts.
